timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped programmable down-counter that serves as the device at the CPU data-bus ranges 0x7F00–0x7F0B (DEV1) and 0x7F10–0x7F1B (DEV2); one instance per range. It answers aligned word loads and stores that the data-memory stage has already range- and alignment-checked and forwarded through the bridge. It raises a level interrupt request toward the CP0 interrupt logic when its count expires.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  reset, synchronous, active-high; clock clk.
- Addr  input  2  word select = bus address bits [3:2]: 00 CTRL, 01 PRESET, 10 COUNT, 11 unused.
- WE  input  1  store strobe for the selected word, valid for one cycle.
- WD  input  32  store data.
- RD  output  32  load data for the selected word, combinational.
- IRQ  output  1  interrupt request, level.

## Operation
- Registers:
  - CTRL: bits [3:0] stored (bit0 Enable, bits[2:1] Mode, bit3 IM); bits [31:4] read 0.
  - PRESET: 32-bit reload value.
  - COUNT: 32-bit, read-only; stores to it are ignored.
  - Internal: irq_pending and a 2-bit state.
- RD: Addr 00 gives {28'b0, CTRL[3:0]}, 01 gives PRESET, 10 gives COUNT, 11 gives 0.
- IRQ = CTRL.IM & irq_pending.
- States:
  - IDLE: if Enable, go to LOAD; else stay.
  - LOAD: COUNT <= PRESET; go to CNT unconditionally.
  - CNT:
    - Enable=0: go to IDLE; COUNT holds.
    - Else COUNT>1: COUNT <= COUNT-1.
    - Else (COUNT<=1): COUNT <= 0, irq_pending <= 1, go to INT.
  - INT: go to IDLE.
    - Mode 00, 10, 11 (one-shot): CTRL.Enable <= 0; irq_pending holds.
    - Mode 01 (auto-reload): irq_pending <= 0, giving a one-cycle pulse; Enable stays set, so the counter reloads.
- irq_pending clears on any store to CTRL or PRESET. This clear has priority over a set in the same cycle.
- Store to CTRL in the same cycle as the INT-state Enable clear: the CPU store wins.
- Store to PRESET does not affect a running count; it takes effect at the next LOAD.
- Re-enabling after a disable always reloads from PRESET; there is no resume.
- Unsigned arithmetic; COUNT never wraps below 0.

## Timing
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_pending=0, state IDLE, IRQ=0, RD reflects the zeroed registers.
- Reset has priority over every store and state transition, including mid-count.
- Stores take effect at the edge where WE is sampled high. A load in the following cycle returns the new value.
- Enable-store at edge t, PRESET=N≥1:
  - t+1: LOAD.
  - t+2: COUNT=N.
  - t+k+2: COUNT=N-k, decrementing once per edge until COUNT=1 at t+N+1.
  - t+N+2: COUNT=0, state INT, irq_pending=1.
- PRESET=0 or 1 expires at t+3.
- Auto-reload: IRQ is high for exactly one cycle. The period between COUNT=N reloads is N+3 cycles.
- Disable-store during CNT at edge s: state IDLE at s+1, COUNT frozen. Disable during LOAD: CNT is entered, then IDLE one edge later.

## Test plan
- Reset → RD reads 0 at Addr 00/01/10/11, IRQ=0. Store COUNT=0x55 → COUNT still reads 0.
- One-shot: PRESET=5, CTRL=0x9 → COUNT reads 5,4,3,2,1,0 on consecutive cycles; IRQ rises 7 cycles after the CTRL store and stays high; CTRL then reads 0x8. Store PRESET=5 → IRQ=0 next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → IRQ pulses high for 1 cycle, repeating every 6 cycles; CTRL stays 0xB.
- Mask: PRESET=2, CTRL=0x1 → expiry gives IRQ=0. Then store CTRL=0x8 → irq_pending cleared, IRQ stays 0.
- Disable mid-count: PRESET=100, enable, disable when COUNT=90 → COUNT holds 90 for 20 cycles. Re-enable → COUNT=100 two cycles later.
- Reset mid-count (COUNT=40) with a simultaneous PRESET store → all registers 0, state IDLE, IRQ=0 next cycle.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter
// Memory-mapped programmable down-counter with a level interrupt request.
// One instance serves each bus window (DEV1 / DEV2); the bridge has already
// range- and alignment-checked the access, so only the word select arrives.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high
//   Addr   in   2   word select: 00 CTRL, 01 PRESET, 10 COUNT, 11 unused
//   WE     in   1   store strobe for the selected word
//   WD     in  32   store data
//   RD     out 32   load data for the selected word (combinational)
//   IRQ    out  1   interrupt request, level (CTRL.IM & pending)
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      state, stateNext;
    logic [3:0]  ctrl;          // [0] Enable, [2:1] Mode, [3] IM
    logic [31:0] preset;
    logic [31:0] count;
    logic        irqPending;

    // Datapath controls decoded by the FSM
    logic loadCount, decCount, expire, oneShotDone, pulseDone;

    logic       enable;
    logic [1:0] mode;
    logic       storeCtrl, storePreset;

    assign enable      = ctrl[0];
    assign mode        = ctrl[2:1];
    assign storeCtrl   = WE && (Addr == 2'b00);
    assign storePreset = WE && (Addr == 2'b01);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        loadCount   = 1'b0;
        decCount    = 1'b0;
        expire      = 1'b0;
        oneShotDone = 1'b0;
        pulseDone   = 1'b0;
        case (state)
            S_IDLE: if (enable) stateNext = S_LOAD;
            S_LOAD: begin
                loadCount = 1'b1;
                stateNext = S_CNT;
            end
            S_CNT: begin
                if (!enable) begin
                    stateNext = S_IDLE;
                end else if (count > 32'd1) begin
                    decCount = 1'b1;
                end else begin
                    // COUNT of 0 or 1 both expire here, so COUNT never wraps
                    expire    = 1'b1;
                    stateNext = S_INT;
                end
            end
            S_INT: begin
                stateNext = S_IDLE;
                // Auto-reload keeps Enable so IDLE goes straight back to LOAD
                if (mode == 2'b01) pulseDone   = 1'b1;
                else               oneShotDone = 1'b1;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl       <= 4'd0;
            preset     <= 32'd0;
            count      <= 32'd0;
            irqPending <= 1'b0;
        end else begin
            if (loadCount)     count <= preset;
            else if (decCount) count <= count - 32'd1;
            else if (expire)   count <= 32'd0;

            // A CPU store to CTRL overrides the one-shot Enable clear
            if (storeCtrl)        ctrl    <= WD[3:0];
            else if (oneShotDone) ctrl[0] <= 1'b0;

            // PRESET only feeds the next LOAD; a running count is untouched
            if (storePreset) preset <= WD;

            // Any CTRL/PRESET store acknowledges, and beats a same-cycle set
            if (storeCtrl || storePreset) irqPending <= 1'b0;
            else if (expire)              irqPending <= 1'b1;
            else if (pulseDone)           irqPending <= 1'b0;
        end
    end

    always_comb begin
        RD = 32'd0;
        case (Addr)
            2'b00:   RD = {28'd0, ctrl};
            2'b01:   RD = preset;
            2'b10:   RD = count;
            default: RD = 32'd0;
        endcase
    end

    assign IRQ = ctrl[3] & irqPending;

endmodule

// File: tb/tb_timer_counter.sv
// Testbench for timer_counter: every cycle the driver pushes the expected
// RD/IRQ (from a behavioural model of the register/timer rules) into a queue;
// a monitor on the falling edge pops and compares against the DUT.
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .WD   (WD),
        .RD   (RD),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [1:0]  addr;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   ncmp   = 0;
    int   nmis   = 0;
    int   cycNo  = 0;
    bit   chk    = 0;

    // Reference model: registers plus a phase name from the timer description
    localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;
    logic [3:0]  mCtrl   = 4'd0;
    logic [31:0] mPreset = 32'd0;
    logic [31:0] mCount  = 32'd0;
    bit          mPend   = 0;
    int          mPhase  = P_IDLE;

    function automatic logic [31:0] mRead(input logic [1:0] a);
        if (a == 2'd0) return {28'd0, mCtrl};
        if (a == 2'd1) return mPreset;
        if (a == 2'd2) return mCount;
        return 32'd0;
    endfunction

    function automatic void mStep(input bit r, input bit w, input logic [1:0] a,
                                  input logic [31:0] d);
        logic [3:0]  nCtrl;
        logic [31:0] nCount;
        bit          nPend;
        int          nPhase;
        if (r) begin
            mCtrl = 0; mPreset = 0; mCount = 0; mPend = 0; mPhase = P_IDLE;
            return;
        end
        nCtrl = mCtrl; nCount = mCount; nPend = mPend; nPhase = mPhase;
        if (mPhase == P_IDLE) begin
            if (mCtrl[0]) nPhase = P_LOAD;
        end else if (mPhase == P_LOAD) begin
            nCount = mPreset; nPhase = P_CNT;
        end else if (mPhase == P_CNT) begin
            if (!mCtrl[0]) nPhase = P_IDLE;
            else if (mCount > 1) nCount = mCount - 1;
            else begin nCount = 0; nPend = 1; nPhase = P_INT; end
        end else begin
            nPhase = P_IDLE;
            if (mCtrl[2:1] == 2'b01) nPend = 0;
            else nCtrl[0] = 1'b0;
        end
        // CPU stores applied last: they win over the timer's own updates
        if (w && a == 2'd0) begin nCtrl = d[3:0]; nPend = 0; end
        if (w && a == 2'd1) begin mPreset = d;     nPend = 0; end
        mCtrl = nCtrl; mCount = nCount; mPend = nPend; mPhase = nPhase;
    endfunction

    task automatic cyc(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        reset = r; WE = w; Addr = a; WD = d;
        if (chk) begin
            e.rd = mRead(a); e.irq = mCtrl[3] & mPend; e.addr = a; e.cyc = cycNo;
            q.push_back(e);
        end
        @(posedge clk);
        mStep(r, w, a, d);
        cycNo++;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            ncmp += 2;
            if (RD !== e.rd) begin
                nmis++;
                $display("FAIL rd cyc=%0d addr=%0d: got %h want %h", e.cyc, e.addr, RD, e.rd);
            end
            if (IRQ !== e.irq) begin
                nmis++;
                $display("FAIL irq cyc=%0d: got %b want %b", e.cyc, IRQ, e.irq);
            end
        end
    end

    initial begin
        bit          r, w;
        logic [1:0]  a;
        logic [31:0] d;

        // Initial reset, unchecked while DUT state is unknown
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk = 1;

        // Reset values, and COUNT is read-only
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'(i), 0);
        cyc(0, 1, 2, 32'h55);
        cyc(0, 0, 2, 0);

        // One-shot with IM
        cyc(0, 1, 1, 5);
        cyc(0, 1, 0, 32'h9);
        for (int i = 0; i < 10; i++) cyc(0, 0, 2, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 5);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);

        // Auto-reload
        cyc(0, 1, 1, 3);
        cyc(0, 1, 0, 32'hB);
        for (int i = 0; i < 20; i++) cyc(0, 0, 2, 0);
        cyc(0, 0, 0, 0);

        // Masked expiry, then unmask after acknowledging via CTRL store
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 2, 0);
        cyc(0, 1, 1, 2);
        cyc(0, 1, 0, 32'h1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 2, 0);
        cyc(0, 1, 0, 32'h8);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

        // Disable mid-count: store when COUNT shows 91 so it freezes at 90
        cyc(0, 1, 1, 100);
        cyc(0, 1, 0, 32'h1);
        for (int k = 0; k < 200 && mCount != 91; k++) cyc(0, 0, 2, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 2, 0);
        cyc(0, 1, 0, 32'h1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 2, 0);

        // Reset mid-count with a simultaneous PRESET store
        for (int k = 0; k < 200 && mCount != 40; k++) cyc(0, 0, 2, 0);
        cyc(1, 1, 1, 32'h1234);
        for (int i = 0; i < 4; i++) cyc(0, 0, 2'(i), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 7) == 0);
            a = 2'($urandom_range(0, 3));
            if (a == 2'd1)      d = $urandom_range(0, 12);
            else if (a == 2'd0) d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 15);
            else                d = $urandom;
            cyc(r, w, a, d);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 4 && q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        ncmp++;
        if (q.size() != 0) begin
            nmis++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
        $finish;
    end

endmodule
